instr_broadcast_fifo: RTL and testbench

//   Parametrised instruction buffer between the host command path and the core array.

---
 rtl/instr_broadcast_fifo.sv | 161 ++++++++++++++++
 tb/tb_instr_broadcast_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_broadcast_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : instr_broadcast_fifo
//  Description : Circular instruction FIFO whose head is held in an output
//                register and broadcast to every enabled core until all ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_broadcast_fifo #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 32,
    parameter int NUM_CORES    = 4,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    input  logic [DATA_W-1:0]            in_data_i,
    output logic                         in_ready_o,
    input  logic [NUM_CORES-1:0]         core_enable_i,
    input  logic [NUM_CORES-1:0]         core_ready_i,
    output logic                         out_valid_o,
    output logic [DATA_W-1:0]            out_data_o,
    output logic [NUM_CORES-1:0]         ack_mask_o,
    output logic                         dispatched_o,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level_o,
    output logic                         almost_full_o,
    output logic                         overflow_err_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_afull = c_cnt_w'(AFULL_THRESH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]   fill_q, fill_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic [NUM_CORES-1:0] ack_q, ack_d;
    logic                 disp_q, disp_d;
    logic                 ovf_q, ovf_d;

    logic                 w_in_ready;
    logic                 w_push;
    logic [NUM_CORES-1:0] w_done;
    logic [NUM_CORES-1:0] w_accept;
    logic                 w_complete;
    logic                 w_load;
    logic                 w_pop;
    logic                 w_bypass;
    logic                 w_wr_en;

    // in_ready depends only on registered fill and the control inputs, never on core_ready.
    assign w_in_ready = !reset && !flush_i && (fill_q < c_depth);
    assign w_push     = in_valid_i && w_in_ready;

    // Disabled cores count as already acknowledged.
    assign w_done     = ack_q | (core_ready_i & core_enable_i) | ~core_enable_i;
    assign w_complete = out_valid_q && (&w_done);
    assign w_accept   = out_valid_q ? (core_ready_i & core_enable_i & ~ack_q) : '0;

    assign w_load   = !out_valid_q || w_complete;
    assign w_pop    = w_load && (fill_q != '0);
    assign w_bypass = w_load && (fill_q == '0) && w_push;
    assign w_wr_en  = w_push && !w_bypass;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ack_d       = ack_q;
        disp_d      = 1'b0;
        ovf_d       = ovf_q;

        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fill_d      = '0;
            out_valid_d = 1'b0;
            ack_d       = '0;
            ovf_d       = 1'b0;
        end else begin
            if (in_valid_i && !w_in_ready) begin
                ovf_d = 1'b1;
            end

            disp_d = w_complete;
            ack_d  = w_complete ? '0 : (ack_q | w_accept);

            if (w_load) begin
                if (fill_q != '0) begin
                    out_data_d  = mem_q[rd_ptr_q];
                    out_valid_d = 1'b1;
                    rd_ptr_d    = rd_ptr_q + c_ptr_one;
                end else if (w_push) begin
                    out_data_d  = in_data_i;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end

            if (w_wr_en) begin
                wr_ptr_d = wr_ptr_q + c_ptr_one;
            end

            case ({w_wr_en, w_pop})
                2'b10:   fill_d = fill_q + c_cnt_one;
                2'b01:   fill_d = fill_q - c_cnt_one;
                default: fill_d = fill_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ack_q       <= '0;
            disp_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ack_q       <= ack_d;
            disp_q      <= disp_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    assign in_ready_o     = w_in_ready;
    assign out_valid_o    = out_valid_q;
    assign out_data_o     = out_data_q;
    assign ack_mask_o     = ack_q;
    assign dispatched_o   = disp_q;
    assign fill_level_o   = fill_q;
    assign almost_full_o  = (fill_q >= c_afull);
    assign overflow_err_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_broadcast_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_broadcast_fifo
//  Description : Randomized and directed bench for instr_broadcast_fifo using a
//                queue-based reference model of the FIFO plus output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_broadcast_fifo;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 32;
    localparam int NUM_CORES = 4;
    localparam int AFULL     = DEPTH - 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 in_valid;
    logic [DATA_W-1:0]    in_data;
    logic                 in_ready;
    logic [NUM_CORES-1:0] core_enable;
    logic [NUM_CORES-1:0] core_ready;
    logic                 out_valid;
    logic [DATA_W-1:0]    out_data;
    logic [NUM_CORES-1:0] ack_mask;
    logic                 dispatched;
    logic [5:0]           fill_level;
    logic                 almost_full;
    logic                 overflow_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DATA_W-1:0]    mq[$];
    logic                 m_ov;
    logic [DATA_W-1:0]    m_od;
    logic [NUM_CORES-1:0] m_ack;
    logic                 m_disp;
    logic                 m_ovf;

    always #5 clk = ~clk;

    instr_broadcast_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CORES(NUM_CORES), .AFULL_THRESH(AFULL)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_data_i      (in_data),
        .in_ready_o     (in_ready),
        .core_enable_i  (core_enable),
        .core_ready_i   (core_ready),
        .out_valid_o    (out_valid),
        .out_data_o     (out_data),
        .ack_mask_o     (ack_mask),
        .dispatched_o   (dispatched),
        .fill_level_o   (fill_level),
        .almost_full_o  (almost_full),
        .overflow_err_o (overflow_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, advance
    // the model, then check registered outputs at the following negedge.
    task automatic step(input bit r, input bit f, input bit iv, input logic [DATA_W-1:0] d,
                        input logic [NUM_CORES-1:0] en, input logic [NUM_CORES-1:0] rdy);
        bit                   room, push, comp;
        logic [NUM_CORES-1:0] done;
        reset = r; flush = f; in_valid = iv; in_data = d; core_enable = en; core_ready = rdy;
        #1;
        check("in_ready", in_ready, (!r && !f && mq.size() < DEPTH));
        check("almost_full", almost_full, (mq.size() >= AFULL));

        if (r || f) begin
            mq.delete();
            m_ov = 0; m_ack = '0; m_disp = 0; m_ovf = 0;
            if (r) m_od = '0;
        end else begin
            room = (mq.size() < DEPTH);
            push = iv && room;
            if (iv && !room) m_ovf = 1;
            done = m_ack | (rdy & en) | ~en;
            comp = m_ov && (&done);
            m_disp = comp;
            if (comp) m_ack = '0;
            else if (m_ov) m_ack = m_ack | (rdy & en);
            if (!m_ov || comp) begin
                if (mq.size() > 0) begin
                    m_od = mq.pop_front();
                    m_ov = 1;
                    if (push) mq.push_back(d);
                end else if (push) begin
                    m_od = d;
                    m_ov = 1;
                end else begin
                    m_ov = 0;
                end
            end else if (push) begin
                mq.push_back(d);
            end
        end

        @(posedge clk);
        @(negedge clk);
        check("out_valid", out_valid, m_ov);
        check("out_data", out_data, m_od);
        check("ack_mask", ack_mask, m_ack);
        check("dispatched", dispatched, m_disp);
        check("fill_level", fill_level, mq.size());
        check("overflow_err", overflow_err, m_ovf);
    endtask

    initial begin
        int p_push, p_rdy;
        logic [NUM_CORES-1:0] en;
        reset = 1; flush = 0; in_valid = 0; in_data = '0; core_enable = '1; core_ready = '0;
        mq.delete(); m_ov = 0; m_od = '0; m_ack = '0; m_disp = 0; m_ovf = 0;
        @(posedge clk);
        @(negedge clk);
        step(1, 0, 0, 0, 4'hF, 4'h0);
        check("reset_out_valid", out_valid, 0);
        check("reset_fill", fill_level, 0);

        // Push into empty block with all cores ready
        step(0, 0, 1, 32'hDEADBEEF, 4'hF, 4'hF);
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 32'hDEADBEEF);
        step(0, 0, 0, 0, 4'hF, 4'hF);
        check("t1_dispatched", dispatched, 1);
        check("t1_fill", fill_level, 0);

        // Staggered acknowledgements
        step(0, 0, 1, 32'h0000_A5A5, 4'hF, 4'h0);
        step(0, 0, 0, 0, 4'hF, 4'b0001);
        check("t2_ack1", ack_mask, 4'b0001);
        step(0, 0, 0, 0, 4'hF, 4'b0100);
        check("t2_ack2", ack_mask, 4'b0101);
        step(0, 0, 0, 0, 4'hF, 4'b0000);
        check("t2_nodisp", dispatched, 0);
        step(0, 0, 0, 0, 4'hF, 4'b1010);
        check("t2_disp", dispatched, 1);
        step(0, 0, 0, 0, 4'hF, 4'b0000);
        check("t2_single_pulse", dispatched, 0);

        // Fill to capacity with idle cores, then overflow
        for (int i = 0; i < 33; i++) step(0, 0, 1, i, 4'hF, 4'h0);
        check("t3_fill", fill_level, 32);
        check("t3_head", out_data, 0);
        step(0, 0, 1, 33, 4'hF, 4'h0);
        check("t3_overflow", overflow_err, 1);
        for (int i = 0; i < 25; i++) step(0, 0, 0, 0, 4'hF, 4'hF);
        check("t3_fill7", fill_level, 7);
        check("t3_order", out_data, 25);

        // Partial ack then flush
        step(0, 0, 0, 0, 4'hF, 4'b0011);
        check("t6_ack", ack_mask, 4'b0011);
        step(0, 1, 1, 32'h1234, 4'hF, 4'hF);
        check("t6_valid", out_valid, 0);
        check("t6_disp", dispatched, 0);
        check("t6_ovf", overflow_err, 0);
        step(0, 0, 1, 32'hCAFE0001, 4'hF, 4'h0);
        check("t6_bypass", out_data, 32'hCAFE0001);

        // Push coinciding with completion at fill_level 5
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h100 + i, 4'hF, 4'h0);
        check("t4_fill5", fill_level, 5);
        step(0, 0, 1, 32'h200, 4'hF, 4'hF);
        check("t4_fill_hold", fill_level, 5);
        check("t4_oldest", out_data, 32'h100);

        // Enable-driven completion
        step(0, 0, 0, 0, 4'b0010, 4'b0010);
        check("t5_one_core", dispatched, 1);
        step(0, 0, 0, 0, 4'hF, 4'b0001);
        step(0, 0, 0, 0, 4'h0, 4'h0);
        check("t5_all_off", dispatched, 1);

        // Randomized phases
        for (int ph = 0; ph < 24; ph++) begin
            p_push = $urandom_range(100);
            p_rdy  = $urandom_range(100);
            for (int c = 0; c < 150; c++) begin
                en = ($urandom_range(9) < 7) ? 4'hF : 4'($urandom);
                step(($urandom_range(599) == 0), ($urandom_range(199) == 0),
                     ($urandom_range(99) < p_push), $urandom,
                     en, 4'($urandom) & {4{$urandom_range(99) < p_rdy}});
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
